// File: rtl/dtc_dcs_pkg.sv
// Shared definitions for the DTC DCS command executor: address fields,
// target codes, reply error codes and one-hot FSM state encodings.
package dtc_dcs_pkg;

    localparam logic [3:0] TGT_LOCAL = 4'h0;
    localparam logic [3:0] TGT_FEE   = 4'h1;

    localparam int TGT_MSB = 31;
    localparam int TGT_LSB = 28;
    localparam int RW_BIT  = 27;
    localparam int REG_MSB = 15;

    localparam logic [31:0] ERR_TIMEOUT = 32'hDEAD_0001;
    localparam logic [31:0] ERR_BADCMD  = 32'hDEAD_0002;

    localparam logic [6:0] ST_IDLE     = 7'b000_0001;
    localparam logic [6:0] ST_LATCH    = 7'b000_0010;
    localparam logic [6:0] ST_LOCAL    = 7'b000_0100;
    localparam logic [6:0] ST_FWD_REQ  = 7'b000_1000;
    localparam logic [6:0] ST_FWD_WAIT = 7'b001_0000;
    localparam logic [6:0] ST_REPLY    = 7'b010_0000;
    localparam logic [6:0] ST_DV_LOW   = 7'b100_0000;

    function automatic logic [3:0] cmd_target(input logic [31:0] addr);
        return addr[TGT_MSB:TGT_LSB];
    endfunction

endpackage

// File: rtl/dtc_dcs_regbank.sv
// Local DTC control register bank: single write port, combinational read
// port and the whole array exported as a flattened bus.
module dtc_dcs_regbank
    import dtc_dcs_pkg::*;
#(
    parameter int NUM_REG = 16,
    parameter int IDX_W   = $clog2(NUM_REG)
) (
    input  logic                    gclk_40m,
    input  logic                    reset_n,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_idx,
    input  logic [31:0]             wr_data,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic [31:0]             rd_data,
    output logic [NUM_REG*32-1:0]   reg_flat
);

    logic [31:0] regs [NUM_REG];

    always_ff @(posedge gclk_40m or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_idx] <= wr_data;
        end
    end

    assign rd_data = regs[rd_idx];

    for (genvar g = 0; g < NUM_REG; g++) begin : g_flat
        assign reg_flat[32*g +: 32] = regs[g];
    end

endmodule

// File: rtl/dtc_dcscmd_exec.sv
// DCS command executor: accepts one parser command at a time, serves it from
// the local register bank or forwards it to the FEE, and returns one reply.
module dtc_dcscmd_exec
    import dtc_dcs_pkg::*;
#(
    parameter int NUM_REG     = 16,
    parameter int TIMEOUT_CYC = 4000
) (
    input  logic                    gclk_40m,
    input  logic                    reset_n,
    input  logic                    udp_cmd_dv,
    input  logic [31:0]             udp_cmd_addr,
    input  logic [31:0]             udp_cmd_data,
    output logic                    udp_cmd_dv_ack,
    output logic                    fee_cmd_dv,
    input  logic                    fee_cmd_ack,
    output logic [31:0]             fee_cmd_addr,
    output logic [31:0]             fee_cmd_data,
    input  logic                    fee_rsp_dv,
    input  logic [31:0]             fee_rsp_data,
    output logic                    rpl_dv,
    input  logic                    rpl_ack,
    output logic [31:0]             rpl_addr,
    output logic [31:0]             rpl_data,
    output logic                    rpl_err,
    output logic [NUM_REG*32-1:0]   reg_bank,
    output logic [15:0]             timeout_cnt
);

    localparam int IDX_W = $clog2(NUM_REG);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [6:0]       state;
    logic [31:0]      cmd_addr;
    logic [31:0]      cmd_data;
    logic [CNT_W-1:0] wait_cnt;
    logic [IDX_W-1:0] reg_idx;
    logic [31:0]      reg_rd_data;
    logic             bad_idx;
    logic             is_read;
    logic             reg_wr_en;

    assign reg_idx   = cmd_addr[IDX_W-1:0];
    assign bad_idx   = |cmd_addr[REG_MSB:IDX_W];
    assign is_read   = cmd_addr[RW_BIT];
    assign reg_wr_en = (state == ST_LOCAL) && !is_read && !bad_idx;

    assign udp_cmd_dv_ack = (state == ST_LATCH);
    assign fee_cmd_addr   = cmd_addr;
    assign fee_cmd_data   = cmd_data;
    assign rpl_addr       = cmd_addr;

    dtc_dcs_regbank #(
        .NUM_REG (NUM_REG),
        .IDX_W   (IDX_W)
    ) u_regbank (
        .gclk_40m (gclk_40m),
        .reset_n  (reset_n),
        .wr_en    (reg_wr_en),
        .wr_idx   (reg_idx),
        .wr_data  (cmd_data),
        .rd_idx   (reg_idx),
        .rd_data  (reg_rd_data),
        .reg_flat (reg_bank)
    );

    // rpl_dv and fee_cmd_dv are registered so that each drops exactly one
    // cycle after its handshake partner acknowledges.
    always_ff @(posedge gclk_40m or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            cmd_addr    <= '0;
            cmd_data    <= '0;
            wait_cnt    <= '0;
            fee_cmd_dv  <= 1'b0;
            rpl_dv      <= 1'b0;
            rpl_data    <= '0;
            rpl_err     <= 1'b0;
            timeout_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (udp_cmd_dv) begin
                        cmd_addr <= udp_cmd_addr;
                        cmd_data <= udp_cmd_data;
                        state    <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    rpl_err <= 1'b0;
                    case (cmd_target(cmd_addr))
                        TGT_LOCAL: state <= ST_LOCAL;
                        TGT_FEE: begin
                            fee_cmd_dv <= 1'b1;
                            state      <= ST_FWD_REQ;
                        end
                        default: begin
                            rpl_data <= ERR_BADCMD;
                            rpl_err  <= 1'b1;
                            state    <= ST_REPLY;
                        end
                    endcase
                end
                ST_LOCAL: begin
                    if (bad_idx) begin
                        rpl_data <= ERR_BADCMD;
                        rpl_err  <= 1'b1;
                    end else if (is_read) begin
                        rpl_data <= reg_rd_data;
                    end else begin
                        rpl_data <= cmd_data;
                    end
                    state <= ST_REPLY;
                end
                ST_FWD_REQ: begin
                    if (fee_cmd_ack) begin
                        fee_cmd_dv <= 1'b0;
                        wait_cnt   <= '0;
                        state      <= ST_FWD_WAIT;
                    end
                end
                ST_FWD_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    // A response landing on the last wait cycle beats the timeout.
                    if (fee_rsp_dv) begin
                        rpl_data <= fee_rsp_data;
                        rpl_err  <= 1'b0;
                        state    <= ST_REPLY;
                    end else if (wait_cnt == CNT_LAST) begin
                        rpl_data <= ERR_TIMEOUT;
                        rpl_err  <= 1'b1;
                        if (timeout_cnt != 16'hFFFF) begin
                            timeout_cnt <= timeout_cnt + 16'd1;
                        end
                        state <= ST_REPLY;
                    end
                end
                ST_REPLY: begin
                    if (!rpl_dv) begin
                        rpl_dv <= 1'b1;
                    end else if (rpl_ack) begin
                        rpl_dv <= 1'b0;
                        state  <= ST_DV_LOW;
                    end
                end
                ST_DV_LOW: begin
                    if (!udp_cmd_dv) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
